// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the RV32M divide sequencer: bus widths, funct3
// codes for the four divide/remainder ops, the sequencer state encoding
// and a small two's-complement helper.
package div_ctrl_pkg;

   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;

   localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
   localparam logic [REG_BUS-1:0] ONES_WORD = '1;
   localparam logic [REG_BUS-1:0] ONE_WORD  = {{(REG_BUS-1){1'b0}}, 1'b1};
   localparam logic [REG_BUS-1:0] MIN_INT   = {1'b1, {(REG_BUS-1){1'b0}}};

   localparam logic [2:0] INST_DIV  = 3'b100;
   localparam logic [2:0] INST_DIVU = 3'b101;
   localparam logic [2:0] INST_REM  = 3'b110;
   localparam logic [2:0] INST_REMU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_CALC  = 2'd2,
      ST_END   = 2'd3
   } div_state_e;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [REG_BUS-1:0] neg_if(input logic [REG_BUS-1:0] v,
                                                 input logic neg);
      return neg ? ((~v) + ONE_WORD) : v;
   endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration: shift {rem,quot} left by one, trial
// subtract the divisor magnitude from the widened partial remainder and
// shift in a quotient bit of 1 when the difference is non-negative.
module div_ctrl_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quot,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quot_next
);

   logic [W:0] shifted;
   logic [W:0] trial;

   assign shifted = {rem, quot[W-1]};
   assign trial   = shifted - {1'b0, divisor};

   // A borrow into bit W means the shifted remainder was below the divisor.
   always_comb begin
      rem_next  = shifted[W-1:0];
      quot_next = {quot[W-2:0], 1'b0};
      if (!trial[W]) begin
         rem_next  = trial[W-1:0];
         quot_next = {quot[W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Iterative RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
// Accepts an op from execute, stalls the pipeline while dividing one
// quotient bit per cycle, then presents the result with a one-cycle
// register write-back strobe.
// Optional build macro DIV_EARLY_OUT_EN: finish in the START cycle when
// |dividend| < |divisor| (quotient 0, remainder = dividend).
//
// Handshake: an op is accepted at a rising edge where the sequencer is
// idle, start_i=1 and flush_i=0. From that request cycle until write-back
// stall_o holds the pipeline; start_i raised while busy is ignored. The
// result is only meaningful in the single cycle ready_o (= reg_wen_o) is 1.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W     = REG_BUS,
   parameter int REG_ADDR_W = REG_ADDR_BUS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_W-1:0]     dividend_i,
   input  logic [DATA_W-1:0]     divisor_i,
   input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  stall_o,
   output logic [DATA_W-1:0]     result_o,
   output logic                  ready_o,
   output logic                  reg_wen_o,
   output logic [REG_ADDR_W-1:0] reg_w_addr_o
);

   div_state_e state, state_next;

   logic [DATA_W-1:0]     dvd_q;
   logic [DATA_W-1:0]     dvs_q;
   logic [DATA_W-1:0]     quot_q;
   logic [DATA_W-1:0]     rem_q;
   logic [DATA_W-1:0]     result_q;
   logic [2:0]            funct3_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [4:0]            cnt_q;

   logic                  accept;
   logic                  is_signed;
   logic                  is_rem;
   logic                  dvd_neg;
   logic                  dvs_neg;
   logic [DATA_W-1:0]     dvd_mag;
   logic [DATA_W-1:0]     dvs_mag;
   logic                  div_zero;
   logic                  overflow;
   logic                  early_out;
   logic [DATA_W-1:0]     rem_step;
   logic [DATA_W-1:0]     quot_step;
   logic [DATA_W-1:0]     quot_fix;
   logic [DATA_W-1:0]     rem_fix;
   logic [DATA_W-1:0]     calc_result;

   assign accept    = (state == ST_IDLE) && start_i && !flush_i;

   assign is_signed = (funct3_q == INST_DIV) || (funct3_q == INST_REM);
   assign is_rem    = (funct3_q == INST_REM) || (funct3_q == INST_REMU);
   assign dvd_neg   = is_signed && dvd_q[DATA_W-1];
   assign dvs_neg   = is_signed && dvs_q[DATA_W-1];
   assign dvd_mag   = neg_if(dvd_q, dvd_neg);
   assign dvs_mag   = neg_if(dvs_q, dvs_neg);

   assign div_zero  = (dvs_q == ZERO_WORD);
   assign overflow  = is_signed && (dvd_q == MIN_INT) && (dvs_q == ONES_WORD);

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (dvd_mag < dvs_mag);
`else
   assign early_out = 1'b0;
`endif

   div_ctrl_step #(
      .W(DATA_W)
   ) u_step (
      .rem      (rem_q),
      .quot     (quot_q),
      .divisor  (dvs_mag),
      .rem_next (rem_step),
      .quot_next(quot_step)
   );

   // The quotient is negative when operand signs differ; the remainder
   // follows the dividend's sign. Applied to the final iteration's output.
   assign quot_fix    = neg_if(quot_step, dvd_neg ^ dvs_neg);
   assign rem_fix     = neg_if(rem_step, dvd_neg);
   assign calc_result = is_rem ? rem_fix : quot_fix;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Next-state and control outputs.
   always_comb begin
      state_next = state;
      busy_o     = 1'b0;
      stall_o    = 1'b0;
      ready_o    = 1'b0;
      case (state)
         ST_IDLE: begin
            stall_o = accept;
            if (accept) state_next = ST_START;
         end
         ST_START: begin
            busy_o  = 1'b1;
            stall_o = 1'b1;
            if (flush_i)                             state_next = ST_IDLE;
            else if (div_zero || overflow || early_out) state_next = ST_END;
            else                                     state_next = ST_CALC;
         end
         ST_CALC: begin
            busy_o  = 1'b1;
            stall_o = 1'b1;
            if (flush_i)              state_next = ST_IDLE;
            else if (cnt_q == 5'd31)  state_next = ST_END;
         end
         ST_END: begin
            busy_o     = 1'b1;
            ready_o    = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign reg_wen_o    = ready_o;
   assign result_o     = ready_o ? result_q : ZERO_WORD;
   assign reg_w_addr_o = ready_o ? rd_q : '0;

   // Operand capture, special-case results and the iteration datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd_q    <= '0;
         dvs_q    <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         result_q <= '0;
         funct3_q <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  dvd_q    <= dividend_i;
                  dvs_q    <= divisor_i;
                  funct3_q <= funct3_i;
                  rd_q     <= reg_w_addr_i;
               end
            end
            ST_START: begin
               if (div_zero) begin
                  result_q <= is_rem ? dvd_q : ONES_WORD;
               end else if (overflow) begin
                  result_q <= is_rem ? ZERO_WORD : MIN_INT;
               end else if (early_out) begin
                  result_q <= is_rem ? dvd_q : ZERO_WORD;
               end else begin
                  quot_q <= dvd_mag;
                  rem_q  <= ZERO_WORD;
                  cnt_q  <= 5'd0;
               end
            end
            ST_CALC: begin
               quot_q <= quot_step;
               rem_q  <= rem_step;
               cnt_q  <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) result_q <= calc_result;
            end
            default: ;
         endcase
      end
   end

endmodule
